// File: rtl/ram_arbiter_2p_pkg.sv
// Shared types for the two-requester RAM arbiter: port ids, the read tag and
// the round-robin winner function.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    typedef enum logic {
        PORT_LS = 1'b0,
        PORT_IF = 1'b1
    } port_id_e;

    typedef struct packed {
        logic     valid;
        port_id_e id;
    } rd_tag_t;

    // Winner assuming at least one request is present; a contested cycle goes
    // to the port that did not receive the previous grant.
    function automatic port_id_e rr_winner(input logic req0, input logic req1,
                                           input port_id_e last);
        port_id_e win;
        if (req0 && req1) begin
            win = (last == PORT_LS) ? PORT_IF : PORT_LS;
        end else if (req1) begin
            win = PORT_IF;
        end else begin
            win = PORT_LS;
        end
        return win;
    endfunction

endpackage

// File: rtl/ram_arbiter_2p_if.sv
// Requester-side handshake bundle and the single-port RAM bundle used by the
// arbiter; "master" is the side that initiates the access.
interface ram_req_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output we, output addr, output wdata,
                    input gnt, input rvalid, input rdata);
    modport slave  (input req, input we, input addr, input wdata,
                    output gnt, output rvalid, output rdata);
endinterface

interface ram_port_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;

    modport master (output wea, output addra, output dina, input douta);
    modport slave  (input wea, input addra, input dina, output douta);
endinterface

// File: rtl/ram_arbiter_2p_rd_tag_pipe.sv
// RAM_LAT-deep shift register carrying {valid, owner} alongside each RAM read,
// so the tag emerges in the same cycle as the matching douta.
module rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int RAM_LAT = 1
) (
    input  logic    clka,
    input  logic    rst,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t [RAM_LAT-1:0] pipe_q;
    rd_tag_t [RAM_LAT-1:0] pipe_d;

    for (genvar gi = 0; gi < RAM_LAT; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign pipe_d[gi] = tag_i;
        end else begin : g_body
            assign pipe_d[gi] = pipe_q[gi-1];
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_o = pipe_q[RAM_LAT-1];

endmodule

// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter sharing one single-port RAM between the load/store port
// (p0) and the instruction-fetch port (p1), with read data routed by tag.
module ram_arbiter_2p
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RAM_LAT = 1
) (
    input  logic       clka,
    input  logic       rst,
    ram_req_if.slave   p0,
    ram_req_if.slave   p1,
    ram_port_if.master ram
);

    port_id_e last_q;
    port_id_e last_d;
    port_id_e win;
    logic     any_gnt;
    logic     sel_if;
    logic     sel_we;
    rd_tag_t  tag_in;
    rd_tag_t  tag_out;

    // Grants are suppressed for the whole reset interval, not just at the edge.
    always_comb begin
        any_gnt = ~rst & (p0.req | p1.req);
        win     = rr_winner(p0.req, p1.req, last_q);
        sel_if  = any_gnt & (win == PORT_IF);
        sel_we  = sel_if ? p1.we : p0.we;

        last_d = last_q;
        if (any_gnt) begin
            last_d = win;
        end

        tag_in.valid = any_gnt & ~sel_we;
        tag_in.id    = sel_if ? PORT_IF : PORT_LS;
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            last_q <= PORT_IF;
        end else begin
            last_q <= last_d;
        end
    end

    assign p0.gnt = any_gnt & ~sel_if;
    assign p1.gnt = sel_if;

    // With no grant the port 0 address/data pass through as a harmless read.
    assign ram.wea   = any_gnt & sel_we;
    assign ram.addra = sel_if ? p1.addr  : p0.addr;
    assign ram.dina  = sel_if ? p1.wdata : p0.wdata;

    rd_tag_pipe #(
        .RAM_LAT (RAM_LAT)
    ) u_tag_pipe (
        .clka  (clka),
        .rst   (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign p0.rvalid = tag_out.valid & (tag_out.id == PORT_LS);
    assign p1.rvalid = tag_out.valid & (tag_out.id == PORT_IF);
    assign p0.rdata  = ram.douta;
    assign p1.rdata  = ram.douta;

endmodule
